// File: rtl/lbist_pkg.sv
// Shared LBIST definitions: controller state encoding and default run geometry.
package lbist_pkg;

  localparam int unsigned PATTERNS_DEF = 16;
  localparam int unsigned ORA_LAT_DEF  = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEED  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } lbist_state_t;

endpackage

// File: rtl/lbist_vpipe.sv
// Valid pipeline: delays the pattern-advance enable so it lines up with the
// analyzer result of the same pattern.
module lbist_vpipe #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic mark
);

  logic [DEPTH-1:0] sr;

  if (DEPTH == 1) begin : g_one
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) sr <= '0;
      else      sr <= en;
    end
  end else begin : g_multi
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) sr <= '0;
      else      sr <= {sr[DEPTH-2:0], en};
    end
  end

  assign mark = sr[DEPTH-1];

endmodule

// File: rtl/lbist_ctrl.sv
// Logic BIST run controller: seeds the TPG, applies PATTERNS patterns, drains the
// analyzer latency and reports pass/fail. Optional first-fail log: LBIST_FAIL_LOG_EN.
module lbist_ctrl
  import lbist_pkg::*;
#(
  parameter int unsigned PATTERNS = PATTERNS_DEF,
  parameter int unsigned ORA_LAT  = ORA_LAT_DEF,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             RES,
  output logic             tpg_load,
  output logic             tpg_en,
  output logic             busy,
  output logic             done,
  output logic             pass
`ifdef LBIST_FAIL_LOG_EN
  ,
  output logic [CNT_W-1:0] fail_idx,
  output logic [CNT_W-1:0] fail_cnt
`endif
);

  localparam int unsigned DR_W = 4;

  lbist_state_t     state;
  logic [CNT_W-1:0] pat_cnt;
  logic [DR_W-1:0]  dr_cnt;
  logic             fail;
  logic             mark;
  logic             hit_c;
  logic             seed_go_c;

  assign hit_c     = mark & RES;
  assign seed_go_c = start && (state == ST_IDLE || state == ST_DONE);

  lbist_vpipe #(
    .DEPTH(ORA_LAT)
  ) u_vpipe (
    .clk (clk),
    .rst (rst),
    .en  (tpg_en),
    .mark(mark)
  );

  // Run sequencing with registered outputs; fail is sticky until the next seed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      pat_cnt  <= '0;
      dr_cnt   <= '0;
      fail     <= 1'b0;
      tpg_load <= 1'b0;
      tpg_en   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
    end else begin
      if (hit_c) fail <= 1'b1;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state    <= ST_SEED;
            tpg_load <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            pass     <= 1'b0;
            fail     <= 1'b0;
          end
        end
        ST_SEED: begin
          state    <= ST_RUN;
          tpg_load <= 1'b0;
          tpg_en   <= 1'b1;
          pat_cnt  <= '0;
        end
        ST_RUN: begin
          if (pat_cnt == CNT_W'(PATTERNS - 1)) begin
            state  <= ST_DRAIN;
            tpg_en <= 1'b0;
            dr_cnt <= '0;
          end else begin
            pat_cnt <= pat_cnt + CNT_W'(1);
          end
        end
        ST_DRAIN: begin
          // The final marked sample lands on this same edge, so fold it into pass.
          if (dr_cnt == DR_W'(ORA_LAT - 1)) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= ~(fail | hit_c);
          end else begin
            dr_cnt <= dr_cnt + DR_W'(1);
          end
        end
        default: begin
          state    <= ST_IDLE;
          tpg_load <= 1'b0;
          tpg_en   <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
          pass     <= 1'b0;
        end
      endcase
    end
  end

`ifdef LBIST_FAIL_LOG_EN
  logic [CNT_W-1:0] res_idx;

  // res_idx numbers the marked samples, i.e. the pattern whose result is on RES.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_idx  <= '0;
      fail_idx <= '0;
      fail_cnt <= '0;
    end else if (seed_go_c) begin
      res_idx  <= '0;
      fail_idx <= '0;
      fail_cnt <= '0;
    end else if (mark) begin
      res_idx <= res_idx + CNT_W'(1);
      if (RES) begin
        if (!fail) fail_idx <= res_idx;
        if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_lbist_ctrl.sv
// Self-checking bench for lbist_ctrl (PATTERNS=8, ORA_LAT=2); the expected run
// schedule and verdict are derived from cycle arithmetic over the RES vector.
module tb_lbist_ctrl;

  localparam int P = 8;
  localparam int L = 2;
  localparam int T = P + L + 2;

  logic clk, rst, start, RES;
  logic tpg_load, tpg_en, busy, done, pass;
`ifdef LBIST_FAIL_LOG_EN
  logic [15:0] fail_idx, fail_cnt;
`endif

  int errors = 0;
  int checks = 0;
  logic        exp_pass;
  logic [15:0] exp_idx, exp_cnt;

  lbist_ctrl #(
    .PATTERNS(P),
    .ORA_LAT (L),
    .CNT_W   (16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .RES     (RES),
    .tpg_load(tpg_load),
    .tpg_en  (tpg_en),
    .busy    (busy),
    .done    (done),
    .pass    (pass)
`ifdef LBIST_FAIL_LOG_EN
    ,
    .fail_idx(fail_idx),
    .fail_cnt(fail_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".tpg_load"}, 32'(tpg_load), 0);
    check({tag, ".tpg_en"},   32'(tpg_en),   0);
    check({tag, ".busy"},     32'(busy),     0);
    check({tag, ".done"},     32'(done),     0);
    check({tag, ".pass"},     32'(pass),     0);
`ifdef LBIST_FAIL_LOG_EN
    check({tag, ".fail_idx"}, 32'(fail_idx), 0);
    check({tag, ".fail_cnt"}, 32'(fail_cnt), 0);
`endif
  endtask

  // Verdict from the rules: results of pattern k appear in cycle k+1+1+L.
  task automatic model(input logic [31:0] resv);
    exp_pass = 1'b1;
    exp_idx  = '0;
    exp_cnt  = '0;
    for (int k = 0; k < P; k++) begin
      if (resv[L + 2 + k]) begin
        if (exp_pass) exp_idx = 16'(k);
        exp_pass = 1'b0;
        exp_cnt  = exp_cnt + 16'd1;
      end
    end
  endtask

  // Caller is in cycle 0 (FSM idle or done); start is sampled at the next edge.
  task automatic do_run(input string name, input logic [31:0] resv, input bit hold);
    model(resv);
    start = 1'b1;
    RES   = resv[0];
    for (int c = 1; c <= T; c++) begin
      step();
      if (c == 1 && !hold) start = 1'b0;
      RES = resv[c];
      check($sformatf("%s.tpg_load@%0d", name, c), 32'(tpg_load), 32'(c == 1));
      check($sformatf("%s.tpg_en@%0d", name, c),   32'(tpg_en),   32'(c >= 2 && c <= P + 1));
      check($sformatf("%s.busy@%0d", name, c),     32'(busy),     32'(c <= P + L + 1));
      check($sformatf("%s.done@%0d", name, c),     32'(done),     32'(c == T));
    end
    check({name, ".pass"}, 32'(pass), 32'(exp_pass));
`ifdef LBIST_FAIL_LOG_EN
    check({name, ".fail_idx"}, 32'(fail_idx), 32'(exp_idx));
    check({name, ".fail_cnt"}, 32'(fail_cnt), 32'(exp_cnt));
`endif
  endtask

  task automatic hold_done(input string name, input int n);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      RES = 1'($urandom);
      step();
      check($sformatf("%s.done@+%0d", name, i), 32'(done), 1);
      check($sformatf("%s.pass@+%0d", name, i), 32'(pass), 32'(exp_pass));
      check($sformatf("%s.busy@+%0d", name, i), 32'(busy | tpg_en | tpg_load), 0);
`ifdef LBIST_FAIL_LOG_EN
      check($sformatf("%s.fail_idx@+%0d", name, i), 32'(fail_idx), 32'(exp_idx));
      check($sformatf("%s.fail_cnt@+%0d", name, i), 32'(fail_cnt), 32'(exp_cnt));
`endif
    end
  endtask

  initial begin
    logic [31:0] rv;
    rst = 1'b0; start = 1'b0; RES = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk) rst = 1'b1;
    step();
    step();
    check_all_zero("idle");

    do_run("clean", 32'h0, 1'b0);
    hold_done("clean_done", 2);

    do_run("res_c7", 32'h1 << 7, 1'b0);
    hold_done("res_c7_done", 2);

    do_run("restart_clean", 32'h0, 1'b0);

    do_run("unmarked", 32'h0000_F00F | (32'h1 << 12), 1'b0);
    hold_done("unmarked_done", 1);

    do_run("all_marked", 32'h0000_0FF0, 1'b0);

    // Reset pulled in the middle of a run.
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    check("midrun.tpg_en@5", 32'(tpg_en), 1);
    rst = 1'b0;
    #1;
    check_all_zero("midrun_rst");
    step();
    check_all_zero("midrun_rst_held");
    @(negedge clk) rst = 1'b1;
    step();
    step();
    check_all_zero("after_release");

    do_run("post_reset", 32'h1 << 11, 1'b0);

    // start held high: back-to-back runs.
    do_run("b2b_0", 32'h0, 1'b1);
    do_run("b2b_1", 32'h1 << 4, 1'b1);
    do_run("b2b_2", 32'h0, 1'b0);
    hold_done("b2b_done", 1);

    for (int r = 0; r < 10; r++) begin
      rv = $urandom & $urandom & $urandom;
      if (r % 3 == 0) rv = rv & 32'hFFFF_F00F;
      do_run($sformatf("rand%0d", r), rv, 1'b0);
      if (r % 2 == 0) hold_done($sformatf("rand%0d_done", r), 1 + r % 3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lbist_ctrl.md
LBIST_CTRL -- requirements
Module: lbist_ctrl

Interface
REQ-001 The block SHALL take parameter PATTERNS, default 16, meaning the number of test patterns applied per run (2..65535).
REQ-002 The block SHALL take parameter ORA_LAT, default 2, meaning the cycles from a tpg_en-high cycle to the cycle its RES value is valid (1..8).
REQ-003 The block SHALL take parameter CNT_W, default 16, meaning the width of the pattern counter and log fields.
REQ-004 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-005 The block SHALL have port rst, input, 1, an asynchronous, active-low reset.
REQ-006 The block SHALL have port start, input, 1, the run request, level-sampled.
REQ-007 The block SHALL have port RES, input, 1, the analyzer compare result (1 = mismatch).
REQ-008 The block SHALL have port tpg_load, output, 1, the pattern-generator seed-load strobe.
REQ-009 The block SHALL have port tpg_en, output, 1, the pattern-generator advance enable.
REQ-010 The block SHALL have port busy, output, 1, high in SEED, RUN and DRAIN.
REQ-011 The block SHALL have port done, output, 1, high in DONE.
REQ-012 The block SHALL have port pass, output, 1, valid while done = 1 (1 = no mismatch seen).

Function
REQ-013 The FSM SHALL have states IDLE, SEED, RUN, DRAIN and DONE, registered with no combinational outputs from inputs.
REQ-014 IDLE SHALL go to SEED on a clock edge with start = 1; in SEED, tpg_load = 1 for exactly one cycle, then the FSM goes to RUN.
REQ-015 RUN SHALL assert tpg_en for exactly PATTERNS consecutive cycles, counted by pat_cnt from 0 to PATTERNS-1, then go to DRAIN.
REQ-016 A valid pipeline (ORA_LAT-deep shift register fed by tpg_en) SHALL mark the cycles in which RES is sampled; RES is ignored in all other cycles.
REQ-017 A sticky fail flag SHALL set on any marked cycle with RES = 1, and SHALL clear only on SEED entry or reset.
REQ-018 DRAIN SHALL last exactly ORA_LAT cycles, so that the last pattern's result is sampled, then go to DONE.
REQ-019 On DONE entry, pass SHALL register as the inverse of the fail flag; done and pass hold in DONE.
REQ-020 In DONE, start = 1 SHALL go directly to SEED (restart); otherwise the FSM stays in DONE.
REQ-021 start SHALL be ignored in SEED, RUN and DRAIN.
REQ-022 Total latency SHALL be fixed: start sampled at edge 0 gives done = 1 in cycle 1+1+PATTERNS+ORA_LAT.

Reset
REQ-023 With rst = 0 at any time, including mid-run, the block SHALL force state IDLE, pat_cnt 0, the valid pipeline and fail flag 0, and all outputs 0.
REQ-024 After reset release, the first transition SHALL require a fresh start = 1 sample.

Configuration
REQ-025 With LBIST_FAIL_LOG_EN defined, the block SHALL add output fail_idx[CNT_W-1:0], the pattern index of the first mismatch.
REQ-026 With LBIST_FAIL_LOG_EN defined, the block SHALL add output fail_cnt[CNT_W-1:0], the mismatch count, saturating at all-ones.
REQ-027 Both log outputs SHALL clear on SEED entry and on reset, and SHALL be stable in DONE.
REQ-028 Without LBIST_FAIL_LOG_EN, the log ports and logic SHALL be absent, with all other behaviour identical.

Structure
REQ-029 The state encoding and the PATTERNS/ORA_LAT defaults SHALL live in shared package lbist_pkg, for reuse by the top-level BIST wrapper.
REQ-030 The valid pipeline SHALL be sub-module lbist_vpipe (parameter DEPTH), containing a shift register with asynchronous active-low clear.

Verification
REQ-031 With PATTERNS=8, ORA_LAT=2, RES held at 0, and start pulsed: tpg_load high in cycle 1, tpg_en high in cycles 2-9, done=1 and pass=1 from cycle 12.
REQ-032 Same setup, with RES=1 only in cycle 7: pass=0; fail_idx=3 and fail_cnt=1 with LBIST_FAIL_LOG_EN.
REQ-033 Same setup, with RES=1 in cycles 0-3 and in cycle 12+: pass=1, because those cycles are unmarked.
REQ-034 Same setup, with rst pulled low in cycle 5: all outputs go 0 immediately and the FSM is in IDLE; the next start gives a full 8-pattern run.
REQ-035 With done=1 and pass=0, start high again: the FSM goes to SEED, the fail flag and log clear, and a clean run ends with pass=1.
REQ-036 With start held high throughout: back-to-back runs occur, each giving exactly one tpg_load and 8 tpg_en cycles.
